// File: rtl/multicycle_ctrl.sv
// Control FSM for a multi-cycle RV32I datapath: sequences FETCH/DECODE/EXEC/MEM/WB,
// drives ALU opcode/operand selects and resolves branches from ALU feedback.
`timescale 1ns/1ps
module multicycle_ctrl #(
   parameter logic [2:0] RESET_STATE = 3'd0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] instr,
   input  logic        mem_ready,
   input  logic [31:0] alu_result,
   input  logic        alu_zero,
   output logic        mem_read,
   output logic        mem_write,
   output logic        ir_write,
   output logic        pc_write,
   output logic [1:0]  pc_sel,
   output logic        target_write,
   output logic        reg_write,
   output logic [1:0]  wb_sel,
   output logic [2:0]  alu_op,
   output logic [1:0]  alu_src_a,
   output logic [1:0]  alu_src_b,
   output logic        alu_swap,
   output logic        illegal,
   output logic [2:0]  state
);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_HALT   = 3'd5
   } state_t;

   typedef enum logic [3:0] {
      K_R, K_I, K_LOAD, K_STORE, K_BRANCH, K_JAL, K_LUI, K_AUIPC, K_BAD
   } kind_t;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_SRL = 3'b100;
   localparam logic [2:0] OP_SRA = 3'b101;
   localparam logic [2:0] OP_UGT = 3'b110;
   localparam logic [2:0] OP_SLT = 3'b111;

   localparam logic [1:0] SA_RS1  = 2'b00;
   localparam logic [1:0] SA_PC   = 2'b01;
   localparam logic [1:0] SA_ZERO = 2'b10;
   localparam logic [1:0] SB_RS2  = 2'b00;
   localparam logic [1:0] SB_IMM  = 2'b01;
   localparam logic [1:0] SB_FOUR = 2'b10;
   localparam logic [1:0] PC_ALU    = 2'b00;
   localparam logic [1:0] PC_TARGET = 2'b01;
   localparam logic [1:0] WB_ALU = 2'b00;
   localparam logic [1:0] WB_MEM = 2'b01;
   localparam logic [1:0] WB_PC  = 2'b10;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   state_t      state_q, state_d;
   kind_t       kind;
   logic [2:0]  exec_op;
   logic        exec_swap;
   logic [1:0]  exec_src_a, exec_src_b;
   logic        f7_ok, is_r, taken;
   logic [6:0]  opcode, funct7;
   logic [2:0]  funct3;
   logic [4:0]  rd;
   logic        unused_bits;

   assign opcode = instr[6:0];
   assign rd     = instr[11:7];
   assign funct3 = instr[14:12];
   assign funct7 = instr[31:25];
   assign state  = state_q;
   assign unused_bits = ^{instr[24:15], alu_result[31:1]};

   // Compare-type branches look at bit 0 of the ALU result; funct3[0] inverts the sense.
   assign taken = (funct3[2] ? alu_result[0] : alu_zero) ^ funct3[0];

   always_comb begin : decode
      kind       = K_BAD;
      exec_op    = OP_ADD;
      exec_swap  = 1'b0;
      exec_src_a = SA_RS1;
      exec_src_b = SB_RS2;
      f7_ok      = 1'b1;
      is_r       = (opcode == 7'b0110011);
      case (opcode)
         7'b0110011, 7'b0010011: begin
            exec_src_b = is_r ? SB_RS2 : SB_IMM;
            case (funct3)
               3'b000: begin
                  exec_op = (is_r && funct7 == F7_ALT) ? OP_SUB : OP_ADD;
                  f7_ok   = !is_r || funct7 == F7_BASE || funct7 == F7_ALT;
               end
               3'b010: begin
                  exec_op = OP_SLT;
                  f7_ok   = !is_r || funct7 == F7_BASE;
               end
               3'b011: begin
                  exec_op   = OP_UGT;
                  exec_swap = 1'b1;
                  f7_ok     = !is_r || funct7 == F7_BASE;
               end
               3'b110: begin
                  exec_op = OP_OR;
                  f7_ok   = !is_r || funct7 == F7_BASE;
               end
               3'b111: begin
                  exec_op = OP_AND;
                  f7_ok   = !is_r || funct7 == F7_BASE;
               end
               3'b101: begin
                  exec_op = (funct7 == F7_ALT) ? OP_SRA : OP_SRL;
                  f7_ok   = funct7 == F7_BASE || funct7 == F7_ALT;
               end
               default: f7_ok = 1'b0;
            endcase
            if (f7_ok) kind = is_r ? K_R : K_I;
         end
         7'b0000011: begin
            exec_src_b = SB_IMM;
            if (funct3 == 3'b010) kind = K_LOAD;
         end
         7'b0100011: begin
            exec_src_b = SB_IMM;
            if (funct3 == 3'b010) kind = K_STORE;
         end
         7'b1100011: begin
            kind = K_BRANCH;
            case (funct3)
               3'b000, 3'b001: exec_op = OP_SUB;
               3'b100, 3'b101: exec_op = OP_SLT;
               3'b110, 3'b111: begin
                  exec_op   = OP_UGT;
                  exec_swap = 1'b1;
               end
               default: kind = K_BAD;
            endcase
         end
         7'b1101111: kind = K_JAL;
         7'b0110111: begin
            kind       = K_LUI;
            exec_src_a = SA_ZERO;
            exec_src_b = SB_IMM;
         end
         7'b0010111: begin
            kind       = K_AUIPC;
            exec_src_a = SA_PC;
            exec_src_b = SB_IMM;
         end
         default: kind = K_BAD;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) state_q <= state_t'(RESET_STATE);
      else     state_q <= state_d;
   end

   always_comb begin : fsm_outputs
      // NOTE: every signal written here is defaulted first so no path can infer a latch.
      state_d      = state_q;
      mem_read     = 1'b0;
      mem_write    = 1'b0;
      ir_write     = 1'b0;
      pc_write     = 1'b0;
      pc_sel       = PC_ALU;
      target_write = 1'b0;
      reg_write    = 1'b0;
      wb_sel       = WB_ALU;
      alu_op       = OP_ADD;
      alu_src_a    = SA_RS1;
      alu_src_b    = SB_RS2;
      alu_swap     = 1'b0;
      illegal      = 1'b0;
      case (state_q)
         S_FETCH: begin
            mem_read  = 1'b1;
            alu_src_a = SA_PC;
            alu_src_b = SB_FOUR;
            if (mem_ready) begin
               ir_write = 1'b1;
               pc_write = 1'b1;
               state_d  = S_DECODE;
            end
         end
         S_DECODE: begin
            alu_src_a    = SA_PC;
            alu_src_b    = SB_IMM;
            target_write = 1'b1;
            state_d      = (kind == K_BAD) ? S_HALT : S_EXEC;
         end
         S_EXEC: begin
            alu_op    = exec_op;
            alu_swap  = exec_swap;
            alu_src_a = exec_src_a;
            alu_src_b = exec_src_b;
            case (kind)
               K_LOAD, K_STORE: state_d = S_MEM;
               K_JAL: begin
                  pc_write = 1'b1;
                  pc_sel   = PC_TARGET;
                  state_d  = S_WB;
               end
               K_BRANCH: begin
                  pc_write = taken;
                  pc_sel   = taken ? PC_TARGET : PC_ALU;
                  state_d  = S_FETCH;
               end
               K_R, K_I, K_LUI, K_AUIPC: state_d = S_WB;
               default: state_d = S_FETCH;
            endcase
         end
         S_MEM: begin
            alu_op    = exec_op;
            alu_swap  = exec_swap;
            alu_src_a = exec_src_a;
            alu_src_b = exec_src_b;
            mem_read  = (kind == K_LOAD);
            mem_write = (kind != K_LOAD);
            if (mem_ready) state_d = (kind == K_LOAD) ? S_WB : S_FETCH;
         end
         S_WB: begin
            reg_write = (rd != 5'd0);
            wb_sel    = (kind == K_LOAD) ? WB_MEM : (kind == K_JAL) ? WB_PC : WB_ALU;
            state_d   = S_FETCH;
         end
         S_HALT: illegal = 1'b1;
         default: state_d = S_FETCH;
      endcase
      // Reset silences every strobe in the same cycle, including mid-handshake.
      if (rst) begin
         mem_read     = 1'b0;
         mem_write    = 1'b0;
         ir_write     = 1'b0;
         pc_write     = 1'b0;
         pc_sel       = PC_ALU;
         target_write = 1'b0;
         reg_write    = 1'b0;
         wb_sel       = WB_ALU;
         alu_op       = OP_ADD;
         alu_src_a    = SA_RS1;
         alu_src_b    = SB_RS2;
         alu_swap     = 1'b0;
         illegal      = 1'b0;
      end
   end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed cases plus random instruction
// streams checked cycle by cycle against a table-driven model of the instruction set.
`timescale 1ns/1ps
module tb_multicycle_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] instr;
   logic        mem_ready;
   logic [31:0] alu_result;
   logic        alu_zero;
   logic        mem_read, mem_write, ir_write, pc_write, target_write, reg_write;
   logic        alu_swap, illegal;
   logic [1:0]  pc_sel, wb_sel, alu_src_a, alu_src_b;
   logic [2:0]  alu_op, state;

   multicycle_ctrl #(.RESET_STATE(3'd0)) dut (
      .clk(clk), .rst(rst), .instr(instr), .mem_ready(mem_ready),
      .alu_result(alu_result), .alu_zero(alu_zero),
      .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
      .pc_write(pc_write), .pc_sel(pc_sel), .target_write(target_write),
      .reg_write(reg_write), .wb_sel(wb_sel), .alu_op(alu_op),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_swap(alu_swap),
      .illegal(illegal), .state(state)
   );

   always #5 clk = ~clk;

   typedef enum int {K_ALU, K_LOAD, K_STORE, K_BRANCH, K_JAL, K_LUI, K_AUIPC} kind_t;
   typedef enum int {B_EQ, B_NE, B_LT, B_GE} bcond_t;

   typedef struct {
      string      name;
      logic [6:0] opc;
      logic [2:0] f3;
      bit         f3_any;
      logic [6:0] f7;
      bit         f7_any;
      kind_t      kind;
      logic [2:0] op;
      bit         swap;
      logic [1:0] sa;
      logic [1:0] sb;
      bcond_t     bc;
   } entry_t;

   typedef struct packed {
      logic       mem_read, mem_write, ir_write, pc_write;
      logic [1:0] pc_sel;
      logic       target_write, reg_write;
      logic [1:0] wb_sel;
      logic [2:0] alu_op;
      logic [1:0] alu_src_a, alu_src_b;
      logic       alu_swap, illegal;
   } outs_t;

   typedef struct {
      int st;
      bit mr;
   } phase_t;

   entry_t tbl[$];
   int     errors = 0;
   int     checks = 0;
   outs_t  act;

   assign act = {mem_read, mem_write, ir_write, pc_write, pc_sel, target_write, reg_write,
                 wb_sel, alu_op, alu_src_a, alu_src_b, alu_swap, illegal};

   task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
      end
   endtask

   function automatic entry_t mk(string n, logic [6:0] opc, logic [2:0] f3, bit f3a,
                                 logic [6:0] f7, bit f7a, kind_t k, logic [2:0] op,
                                 bit sw, logic [1:0] sa, logic [1:0] sb, bcond_t bc);
      entry_t e;
      e.name = n; e.opc = opc; e.f3 = f3; e.f3_any = f3a; e.f7 = f7; e.f7_any = f7a;
      e.kind = k; e.op = op; e.swap = sw; e.sa = sa; e.sb = sb; e.bc = bc;
      return e;
   endfunction

   function automatic int find(string n);
      foreach (tbl[i]) if (tbl[i].name == n) return i;
      return 0;
   endfunction

   function automatic logic [31:0] enc(entry_t e, logic [4:0] rd, logic [4:0] rs1,
                                       logic [4:0] rs2, logic [31:0] rnd);
      logic [6:0] f7 = e.f7_any ? rnd[31:25] : e.f7;
      logic [2:0] f3 = e.f3_any ? rnd[14:12] : e.f3;
      return {f7, rs2, rs1, f3, rd, e.opc};
   endfunction

   function automatic bit br_taken(bcond_t bc, logic [31:0] res);
      case (bc)
         B_EQ:    return res == 32'd0;
         B_NE:    return res != 32'd0;
         B_LT:    return res[0];
         default: return !res[0];
      endcase
   endfunction

   // Expected control word for one cycle, from the state the instruction should be in.
   function automatic outs_t exp_outs(int st, entry_t e, logic [4:0] rd, bit mr, bit tk);
      outs_t o = '0;
      case (st)
         0: begin
            o.mem_read = 1'b1; o.alu_src_a = 2'b01; o.alu_src_b = 2'b10;
            if (mr) begin o.ir_write = 1'b1; o.pc_write = 1'b1; end
         end
         1: begin o.alu_src_a = 2'b01; o.alu_src_b = 2'b01; o.target_write = 1'b1; end
         2: begin
            o.alu_op = e.op; o.alu_swap = e.swap; o.alu_src_a = e.sa; o.alu_src_b = e.sb;
            if (e.kind == K_JAL || (e.kind == K_BRANCH && tk)) begin
               o.pc_write = 1'b1; o.pc_sel = 2'b01;
            end
         end
         3: begin
            o.alu_op = e.op; o.alu_swap = e.swap; o.alu_src_a = e.sa; o.alu_src_b = e.sb;
            o.mem_read = (e.kind == K_LOAD); o.mem_write = (e.kind == K_STORE);
         end
         4: begin
            o.reg_write = (rd != 5'd0);
            o.wb_sel = (e.kind == K_LOAD) ? 2'b01 : (e.kind == K_JAL) ? 2'b10 : 2'b00;
         end
         5: o.illegal = 1'b1;
         default: o = '0;
      endcase
      return o;
   endfunction

   task automatic step(input logic [31:0] ins, input bit mr, input logic [31:0] res,
                       input bit r, input int est, input outs_t eo, input string nm);
      instr = ins; mem_ready = mr; alu_result = res; alu_zero = (res == 32'd0); rst = r;
      @(negedge clk);
      if (est >= 0) check({nm, " state"}, 32'(state), 32'(est));
      check({nm, " outs"}, 32'(act), 32'(eo));
      @(posedge clk);
      #1;
   endtask

   task automatic run_instr(input entry_t e, input logic [31:0] ins, input int fw,
                            input int mw, input logic [31:0] res);
      phase_t ph[$];
      bit tk = (e.kind == K_BRANCH) && br_taken(e.bc, res);
      for (int i = 0; i <= fw; i++) ph.push_back('{0, i == fw});
      ph.push_back('{1, 1'($urandom_range(0, 1))});
      ph.push_back('{2, 1'($urandom_range(0, 1))});
      if (e.kind == K_LOAD || e.kind == K_STORE)
         for (int i = 0; i <= mw; i++) ph.push_back('{3, i == mw});
      if (e.kind != K_STORE && e.kind != K_BRANCH) ph.push_back('{4, 1'($urandom_range(0, 1))});
      foreach (ph[i])
         step(ins, ph[i].mr, res, 1'b0, ph[i].st,
              exp_outs(ph[i].st, e, ins[11:7], ph[i].mr, tk), e.name);
   endtask

   task automatic run_illegal(input logic [31:0] ins, input int fw);
      outs_t halt_o = '0;
      halt_o.illegal = 1'b1;
      for (int i = 0; i <= fw; i++)
         step(ins, i == fw, $urandom, 1'b0, 0, exp_outs(0, tbl[0], 5'd0, i == fw, 1'b0), "bad");
      step(ins, 1'b1, $urandom, 1'b0, 1, exp_outs(1, tbl[0], 5'd0, 1'b1, 1'b0), "bad");
      for (int i = 0; i < 20; i++)
         step($urandom, 1'($urandom_range(0, 1)), $urandom, 1'b0, 5, halt_o, "halt");
      step($urandom, 1'b1, $urandom, 1'b1, 5, '0, "halt_rst");
   endtask

   function automatic logic [31:0] pick_res();
      case ($urandom_range(0, 3))
         0:       return 32'd0;
         1:       return 32'd1;
         2:       return 32'd2;
         default: return $urandom;
      endcase
   endfunction

   initial begin
      logic [31:0] bad[$];
      logic [31:0] rnd;
      entry_t e;
      outs_t  o;

      tbl.push_back(mk("add",  7'b0110011, 3'b000, 0, 7'h00, 0, K_ALU, 3'b000, 0, 2'b00, 2'b00, B_EQ));
      tbl.push_back(mk("sub",  7'b0110011, 3'b000, 0, 7'h20, 0, K_ALU, 3'b001, 0, 2'b00, 2'b00, B_EQ));
      tbl.push_back(mk("and",  7'b0110011, 3'b111, 0, 7'h00, 0, K_ALU, 3'b010, 0, 2'b00, 2'b00, B_EQ));
      tbl.push_back(mk("or",   7'b0110011, 3'b110, 0, 7'h00, 0, K_ALU, 3'b011, 0, 2'b00, 2'b00, B_EQ));
      tbl.push_back(mk("srl",  7'b0110011, 3'b101, 0, 7'h00, 0, K_ALU, 3'b100, 0, 2'b00, 2'b00, B_EQ));
      tbl.push_back(mk("sra",  7'b0110011, 3'b101, 0, 7'h20, 0, K_ALU, 3'b101, 0, 2'b00, 2'b00, B_EQ));
      tbl.push_back(mk("slt",  7'b0110011, 3'b010, 0, 7'h00, 0, K_ALU, 3'b111, 0, 2'b00, 2'b00, B_EQ));
      tbl.push_back(mk("sltu", 7'b0110011, 3'b011, 0, 7'h00, 0, K_ALU, 3'b110, 1, 2'b00, 2'b00, B_EQ));
      tbl.push_back(mk("addi", 7'b0010011, 3'b000, 0, 7'h00, 1, K_ALU, 3'b000, 0, 2'b00, 2'b01, B_EQ));
      tbl.push_back(mk("andi", 7'b0010011, 3'b111, 0, 7'h00, 1, K_ALU, 3'b010, 0, 2'b00, 2'b01, B_EQ));
      tbl.push_back(mk("ori",  7'b0010011, 3'b110, 0, 7'h00, 1, K_ALU, 3'b011, 0, 2'b00, 2'b01, B_EQ));
      tbl.push_back(mk("slti", 7'b0010011, 3'b010, 0, 7'h00, 1, K_ALU, 3'b111, 0, 2'b00, 2'b01, B_EQ));
      tbl.push_back(mk("sltiu",7'b0010011, 3'b011, 0, 7'h00, 1, K_ALU, 3'b110, 1, 2'b00, 2'b01, B_EQ));
      tbl.push_back(mk("srli", 7'b0010011, 3'b101, 0, 7'h00, 0, K_ALU, 3'b100, 0, 2'b00, 2'b01, B_EQ));
      tbl.push_back(mk("srai", 7'b0010011, 3'b101, 0, 7'h20, 0, K_ALU, 3'b101, 0, 2'b00, 2'b01, B_EQ));
      tbl.push_back(mk("lw",   7'b0000011, 3'b010, 0, 7'h00, 1, K_LOAD,  3'b000, 0, 2'b00, 2'b01, B_EQ));
      tbl.push_back(mk("sw",   7'b0100011, 3'b010, 0, 7'h00, 1, K_STORE, 3'b000, 0, 2'b00, 2'b01, B_EQ));
      tbl.push_back(mk("beq",  7'b1100011, 3'b000, 0, 7'h00, 1, K_BRANCH, 3'b001, 0, 2'b00, 2'b00, B_EQ));
      tbl.push_back(mk("bne",  7'b1100011, 3'b001, 0, 7'h00, 1, K_BRANCH, 3'b001, 0, 2'b00, 2'b00, B_NE));
      tbl.push_back(mk("blt",  7'b1100011, 3'b100, 0, 7'h00, 1, K_BRANCH, 3'b111, 0, 2'b00, 2'b00, B_LT));
      tbl.push_back(mk("bge",  7'b1100011, 3'b101, 0, 7'h00, 1, K_BRANCH, 3'b111, 0, 2'b00, 2'b00, B_GE));
      tbl.push_back(mk("bltu", 7'b1100011, 3'b110, 0, 7'h00, 1, K_BRANCH, 3'b110, 1, 2'b00, 2'b00, B_LT));
      tbl.push_back(mk("bgeu", 7'b1100011, 3'b111, 0, 7'h00, 1, K_BRANCH, 3'b110, 1, 2'b00, 2'b00, B_GE));
      tbl.push_back(mk("jal",  7'b1101111, 3'b000, 1, 7'h00, 1, K_JAL,   3'b000, 0, 2'b00, 2'b00, B_EQ));
      tbl.push_back(mk("lui",  7'b0110111, 3'b000, 1, 7'h00, 1, K_LUI,   3'b000, 0, 2'b10, 2'b01, B_EQ));
      tbl.push_back(mk("auipc",7'b0010111, 3'b000, 1, 7'h00, 1, K_AUIPC, 3'b000, 0, 2'b01, 2'b01, B_EQ));

      // Reset: all outputs quiet while rst is high.
      rst = 1'b1; instr = '0; mem_ready = 1'b1; alu_result = '0; alu_zero = 1'b1;
      @(posedge clk);
      #1;
      step($urandom, 1'b1, $urandom, 1'b1, 0, '0, "reset");
      step($urandom, 1'b0, $urandom, 1'b1, 0, '0, "reset");

      // Directed cases.
      e = tbl[find("add")];  run_instr(e, enc(e, 5'd3, 5'd1, 5'd2, $urandom), 0, 0, $urandom);
      e = tbl[find("sltu")]; run_instr(e, enc(e, 5'd4, 5'd1, 5'd2, $urandom), 0, 0, 32'd1);
      e = tbl[find("sub")];  run_instr(e, enc(e, 5'd5, 5'd6, 5'd7, $urandom), 0, 0, 32'd9);
      e = tbl[find("sra")];  run_instr(e, enc(e, 5'd8, 5'd6, 5'd7, $urandom), 0, 0, 32'd3);
      e = tbl[find("lw")];   run_instr(e, enc(e, 5'd5, 5'd2, 5'd0, $urandom), 3, 2, 32'h100);
      e = tbl[find("blt")];  run_instr(e, enc(e, 5'd0, 5'd1, 5'd2, $urandom), 0, 0, 32'd1);
      e = tbl[find("blt")];  run_instr(e, enc(e, 5'd0, 5'd1, 5'd2, $urandom), 0, 0, 32'd0);
      e = tbl[find("beq")];  run_instr(e, enc(e, 5'd0, 5'd1, 5'd2, $urandom), 0, 0, 32'd0);
      e = tbl[find("add")];  run_instr(e, enc(e, 5'd0, 5'd1, 5'd2, $urandom), 0, 0, 32'd7);
      e = tbl[find("jal")];  run_instr(e, enc(e, 5'd1, 5'd0, 5'd0, $urandom), 1, 0, 32'd0);

      // Reset pulsed mid-store while the write is pending.
      e = tbl[find("sw")];
      rnd = enc(e, 5'd0, 5'd3, 5'd4, $urandom);
      step(rnd, 1'b1, 32'h40, 1'b0, 0, exp_outs(0, e, 5'd0, 1'b1, 1'b0), "sw_rst");
      step(rnd, 1'b0, 32'h40, 1'b0, 1, exp_outs(1, e, 5'd0, 1'b0, 1'b0), "sw_rst");
      step(rnd, 1'b0, 32'h40, 1'b0, 2, exp_outs(2, e, 5'd0, 1'b0, 1'b0), "sw_rst");
      step(rnd, 1'b0, 32'h40, 1'b0, 3, exp_outs(3, e, 5'd0, 1'b0, 1'b0), "sw_rst");
      step(rnd, 1'b1, 32'h40, 1'b1, 3, '0, "sw_rst");
      e = tbl[find("or")];   run_instr(e, enc(e, 5'd9, 5'd1, 5'd2, $urandom), 0, 0, 32'd5);

      // Random legal instruction stream.
      for (int n = 0; n < 80; n++) begin
         e = tbl[$urandom_range(0, tbl.size() - 1)];
         rnd = $urandom;
         run_instr(e, enc(e, 5'($urandom), 5'($urandom), 5'($urandom), rnd),
                   ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0,
                   ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0,
                   pick_res());
      end

      // Illegal encodings: unknown opcode first, then bad funct3/funct7 variants.
      bad.push_back({$urandom} | 32'h7f);
      bad.push_back({7'h00, 10'h0a5, 3'b001, 5'd3, 7'b0110011});
      bad.push_back({7'h00, 10'h0a5, 3'b100, 5'd3, 7'b0110011});
      bad.push_back({7'h01, 10'h0a5, 3'b000, 5'd3, 7'b0110011});
      bad.push_back({7'h10, 10'h0a5, 3'b101, 5'd3, 7'b0010011});
      bad.push_back({7'h00, 10'h0a5, 3'b001, 5'd3, 7'b0010011});
      bad.push_back({7'h00, 10'h0a5, 3'b000, 5'd3, 7'b0000011});
      bad.push_back({7'h00, 10'h0a5, 3'b001, 5'd3, 7'b0100011});
      bad.push_back({7'h00, 10'h0a5, 3'b010, 5'd3, 7'b1100011});
      bad.push_back({7'h00, 10'h0a5, 3'b000, 5'd3, 7'b0001111});
      foreach (bad[i]) begin
         run_illegal(bad[i], $urandom_range(0, 1));
         e = tbl[find("addi")];
         run_instr(e, enc(e, 5'd1, 5'd2, 5'd0, $urandom), 0, 0, 32'd4);
      end

      o = '0;
      check("final_reset_outs", 32'(act & '0), 32'(o));
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
